queue_lane_monitor: RTL and testbench
=====================================

QUEUE_LANE_MONITOR -- requirements
Module: queue_lane_monitor

Interface
REQ-001 Parameter NUM_LANES, default 4: number of independent queue lanes, range 1..16.
REQ-002 Parameter CNT_W, default 8: width of each lane occupancy counter.
REQ-003 Parameter MAX_OCC, default 200: lane capacity, at most 2**CNT_W-1.
REQ-004 Parameter DEB_CYCLES, default 4: debounce length in clocks, at least 1.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 fsen  in  NUM_LANES  per-lane front (entry) sensor, asynchronous, high = object present.
REQ-008 bsen  in  NUM_LANES  per-lane back (exit) sensor, asynchronous, high = object present.
REQ-009 occ  out  NUM_LANES*CNT_W  per-lane occupancy; lane i occupies bits [i*CNT_W +: CNT_W].
REQ-010 up_pulse  out  NUM_LANES  one-cycle pulse per counted entry.
REQ-011 down_pulse  out  NUM_LANES  one-cycle pulse per counted exit.
REQ-012 full  out  NUM_LANES  lane occ equals MAX_OCC.
REQ-013 empty  out  NUM_LANES  lane occ equals 0.
REQ-014 err  out  NUM_LANES  sticky: overflow or underflow attempted on the lane.
REQ-015 total  out  CNT_W+4  registered sum of all lane occ values.
REQ-016 err_clr  in  1  synchronous clear of all err bits.

Function
REQ-017 Each sensor SHALL pass through a 2-flop synchroniser before any other use.
REQ-018 The debounced level SHALL change only after the synchronised level has differed from it for DEB_CYCLES consecutive cycles; any agreeing cycle restarts the count.
REQ-019 A rising edge of the debounced fsen SHALL be an entry event; a rising edge of the debounced bsen SHALL be an exit event. Falling edges and held levels SHALL produce no event.
REQ-020 Lane FSM states: IDLE, INC, DEC, SAT. An entry event moves to INC; an exit event moves to DEC; any state returns to IDLE after one cycle unless a new event is present.
REQ-021 INC with occ < MAX_OCC: up_pulse=1 for exactly one cycle and occ increments on the same edge the pulse asserts.
REQ-022 INC with occ = MAX_OCC: move to SAT instead; occ unchanged, no pulse, err set.
REQ-023 DEC with occ > 0: down_pulse=1 for exactly one cycle and occ decrements on the same edge the pulse asserts.
REQ-024 DEC with occ = 0: move to SAT instead; occ unchanged, no pulse, err set.
REQ-025 An entry and an exit event on the same lane in the same cycle SHALL leave occ unchanged and produce no pulse and no err.
REQ-026 Latency from the first clock edge sampling a stable sensor high to pulse assertion SHALL be DEB_CYCLES+3 edges.
REQ-027 full and empty SHALL be registered and consistent with occ in the same cycle.
REQ-028 total SHALL lag occ by exactly one cycle.
REQ-029 err_clr SHALL take priority over err set in the same cycle.
REQ-030 Lanes SHALL be fully independent; events on different lanes in the same cycle SHALL all be counted.

Reset
REQ-031 On rst, the block SHALL reset asynchronously: occ, total, up_pulse, down_pulse, full, err = 0; empty = all ones; FSM = IDLE; synchronisers, debounced levels and debounce counters = 0.
REQ-032 An asserted rst mid-event SHALL discard the event; a sensor held high through reset release SHALL not count until it has fallen and risen again.

Configuration
REQ-033 Macro QMON_DEBOUNCE_EN defined: the debounce stage of REQ-018 is present.
REQ-034 Macro QMON_DEBOUNCE_EN undefined: the synchroniser output feeds edge detection directly, DEB_CYCLES is ignored, and latency is 3 edges.

Structure
REQ-035 Package qmon_pkg SHALL hold the lane FSM state enum (IDLE, INC, DEC, SAT) and the total-width constant.
REQ-036 Per-lane logic SHALL be sub-module qmon_lane (synchroniser, debounce, edge detect, FSM, counter), instantiated NUM_LANES times; the top module holds total and err_clr fan-out.

Verification (defaults, macro defined)
REQ-037 fsen[0] held high for 10 cycles after reset -> up_pulse[0] asserts on edge 7 for one cycle; occ lane0 = 1; empty[0] = 0; total = 1 one cycle later.
REQ-038 fsen[1] glitches high for 3 cycles -> no pulse, occ lane1 = 0.
REQ-039 200 entries on lane 2, then a 201st -> full[2] = 1, occ = 200, no up_pulse, err[2] = 1; err_clr -> err[2] = 0.
REQ-040 bsen[3] rises with occ lane3 = 0 -> no down_pulse, occ = 0, err[3] = 1.
REQ-041 fsen[0] and bsen[0] rise together with occ = 5 -> occ stays 5, no pulses, no err.
REQ-042 rst asserted with fsen[0] high and occ = 3 -> all outputs at reset values; no count after release until fsen[0] falls and rises again.

Source files
------------

// File: rtl/qmon_pkg.sv
// Shared types and constants for the queue lane monitor.
// The lane FSM state type and the extra width that total needs to hold the
// sum of up to 16 lane counters live here.
package qmon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INC,
    DEC,
    SAT
  } lane_state_t;

  // 16 lanes of CNT_W bits each sum into at most CNT_W+4 bits
  localparam int TOTAL_HEADROOM_W = 4;

endpackage

// File: rtl/qmon_lane.sv
// One queue lane: sensor synchronisers, optional debounce, rising-edge event
// detection, lane FSM and the occupancy counter with full/empty/err flags.
// Build option: define QMON_DEBOUNCE_EN to insert the debounce filter between
// the synchronisers and edge detection.
module qmon_lane
  import qmon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MAX_OCC    = 200
`ifdef QMON_DEBOUNCE_EN
  ,
  parameter int DEB_CYCLES = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fsen,
  input  logic             bsen,
  input  logic             err_clr,
  output logic [CNT_W-1:0] occ,
  output logic             up_pulse,
  output logic             down_pulse,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_OCC);

  // bit 0 = front sensor, bit 1 = back sensor
  logic [1:0] sens;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] level;
  logic [1:0] level_q;
  logic [1:0] armed;
  logic [1:0] primed;
  logic [1:0] rise;
  logic       entry;
  logic       leave;

  lane_state_t      state;
  lane_state_t      state_next;
  logic [CNT_W-1:0] occ_next;
  logic             err_set;

  assign sens = {bsen, fsen};

  // Two-flop synchronisers; a sensor only arms once it has been seen low
  // after reset, so a level held through reset release never counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      primed <= '0;
      armed  <= '0;
    end else begin
      sync1  <= sens;
      sync2  <= sync1;
      primed <= {primed[0], 1'b1};
      if (primed[1]) begin
        armed <= armed | ~sync2;
      end
    end
  end

`ifdef QMON_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [1:0][DW-1:0] deb_cnt;

  // Debounce: the filtered level follows only after DEB_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= '0;
      deb_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          level[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign level = sync2;
`endif

  // Previous filtered level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level;
    end
  end

  assign rise  = level & ~level_q & armed;
  assign entry = rise[0];
  assign leave = rise[1];

  // Next-state, counter and flag decisions; pulses decode from the state.
  always_comb begin
    state_next = IDLE;
    occ_next   = occ;
    err_set    = 1'b0;
    up_pulse   = (state == INC);
    down_pulse = (state == DEC);
    if (entry && !leave) begin
      if (occ == MAX_VAL) begin
        state_next = SAT;
        err_set    = 1'b1;
      end else begin
        state_next = INC;
        occ_next   = occ + 1'b1;
      end
    end else if (leave && !entry) begin
      if (occ == '0) begin
        state_next = SAT;
        err_set    = 1'b1;
      end else begin
        state_next = DEC;
        occ_next   = occ - 1'b1;
      end
    end
  end

  // State, counter and registered flags all move on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      occ   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      occ   <= occ_next;
      full  <= (occ_next == MAX_VAL);
      empty <= (occ_next == '0);
      if (err_clr) begin
        err <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_lane_monitor.sv
// Multi-lane queue occupancy monitor: NUM_LANES independent qmon_lane
// instances plus a registered total of all lane occupancies.
// Build option: define QMON_DEBOUNCE_EN to enable sensor debouncing.
module queue_lane_monitor
  import qmon_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int CNT_W      = 8,
  parameter int MAX_OCC    = 200,
  parameter int DEB_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_LANES-1:0]              fsen,
  input  logic [NUM_LANES-1:0]              bsen,
  input  logic                              err_clr,
  output logic [NUM_LANES*CNT_W-1:0]        occ,
  output logic [NUM_LANES-1:0]              up_pulse,
  output logic [NUM_LANES-1:0]              down_pulse,
  output logic [NUM_LANES-1:0]              full,
  output logic [NUM_LANES-1:0]              empty,
  output logic [NUM_LANES-1:0]              err,
  output logic [CNT_W+TOTAL_HEADROOM_W-1:0] total
);

  localparam int TOT_W = CNT_W + TOTAL_HEADROOM_W;

  logic [TOT_W-1:0] sum;

  if ((NUM_LANES < 1) || (NUM_LANES > 16) || (DEB_CYCLES < 1) ||
      (MAX_OCC < 1) || (MAX_OCC > (2 ** CNT_W) - 1)) begin : g_bad_params
    $error("queue_lane_monitor: parameter out of range");
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    qmon_lane #(
      .CNT_W     (CNT_W),
      .MAX_OCC   (MAX_OCC)
`ifdef QMON_DEBOUNCE_EN
      ,
      .DEB_CYCLES(DEB_CYCLES)
`endif
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .fsen      (fsen[i]),
      .bsen      (bsen[i]),
      .err_clr   (err_clr),
      .occ       (occ[i*CNT_W +: CNT_W]),
      .up_pulse  (up_pulse[i]),
      .down_pulse(down_pulse[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .err       (err[i])
    );
  end

  // Combinational sum of the lane counters.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sum = sum + TOT_W'(occ[i*CNT_W +: CNT_W]);
    end
  end

  // Register the sum so total trails occ by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total <= '0;
    end else begin
      total <= sum;
    end
  end

endmodule

// File: tb/tb_queue_lane_monitor.sv
// Randomised self-checking bench for queue_lane_monitor with an event-level
// reference model: sensor waveforms become counted events after a fixed
// latency, and events update per-lane occupancy, pulses and error flags.
module tb_queue_lane_monitor;

  localparam int NUM_LANES  = 4;
  localparam int CNT_W      = 8;
  localparam int MAX_OCC    = 200;
  localparam int DEB_CYCLES = 4;
  localparam int TOT_W      = CNT_W + 4;
  localparam int NSENS      = 2 * NUM_LANES;
  localparam int MAXC       = 8192;
`ifdef QMON_DEBOUNCE_EN
  localparam int DEB_EFF = DEB_CYCLES;
  localparam int LAT     = DEB_CYCLES + 3;
`else
  localparam int DEB_EFF = 1;
  localparam int LAT     = 3;
`endif

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [NUM_LANES-1:0]       fsen = '0;
  logic [NUM_LANES-1:0]       bsen = '0;
  logic                       err_clr = 1'b0;
  logic [NUM_LANES*CNT_W-1:0] occ;
  logic [NUM_LANES-1:0]       up_pulse;
  logic [NUM_LANES-1:0]       down_pulse;
  logic [NUM_LANES-1:0]       full;
  logic [NUM_LANES-1:0]       empty;
  logic [NUM_LANES-1:0]       err;
  logic [TOT_W-1:0]           total;

  always #5 clk = ~clk;

  queue_lane_monitor #(
    .NUM_LANES (NUM_LANES),
    .CNT_W     (CNT_W),
    .MAX_OCC   (MAX_OCC),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fsen      (fsen),
    .bsen      (bsen),
    .err_clr   (err_clr),
    .occ       (occ),
    .up_pulse  (up_pulse),
    .down_pulse(down_pulse),
    .full      (full),
    .empty     (empty),
    .err       (err),
    .total     (total)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  int                   occ_m[NUM_LANES];
  bit                   err_m[NUM_LANES];
  bit [NUM_LANES-1:0]   up_m;
  bit [NUM_LANES-1:0]   dn_m;
  int                   total_m;
  bit [NUM_LANES-1:0]   ent_s[MAXC];
  bit [NUM_LANES-1:0]   ex_s[MAXC];
  bit                   run_v[NSENS];
  int                   run_len[NSENS];
  bit                   filt[NSENS];
  bit                   armed[NSENS];

  logic [NUM_LANES-1:0] fs_cur = '0;
  logic [NUM_LANES-1:0] bs_cur = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NUM_LANES; l++) begin
      occ_m[l] = 0;
      err_m[l] = 1'b0;
    end
    for (int s = 0; s < NSENS; s++) begin
      run_v[s]   = 1'b0;
      run_len[s] = 0;
      filt[s]    = 1'b0;
      armed[s]   = 1'b0;
    end
    for (int e = 0; e < MAXC; e++) begin
      ent_s[e] = '0;
      ex_s[e]  = '0;
    end
  endtask

  // Drive inputs for the next edge and turn confirmed sensor rises into
  // events due LAT edges after the rise was first sampled.
  task automatic applyStimulus(input logic [NUM_LANES-1:0] fs,
                               input logic [NUM_LANES-1:0] bs,
                               input logic clr);
    bit v;
    int due;
    fsen    = fs;
    bsen    = bs;
    err_clr = clr;
    if (!rst) begin
      for (int s = 0; s < NSENS; s++) begin
        if (s < NUM_LANES) v = fs[s];
        else               v = bs[s - NUM_LANES];
        if (run_len[s] > 0 && v == run_v[s]) begin
          run_len[s]++;
        end else begin
          run_v[s]   = v;
          run_len[s] = 1;
        end
        if (!v) armed[s] = 1'b1;
        if (run_len[s] == DEB_EFF && v != filt[s]) begin
          filt[s] = v;
          due = cyc - DEB_EFF + 1 + LAT;
          if (v && armed[s] && due < MAXC) begin
            if (s < NUM_LANES) ent_s[due][s] = 1'b1;
            else               ex_s[due][s - NUM_LANES] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_edge(input int e);
    bit ent, ex, set;
    total_m = 0;
    for (int l = 0; l < NUM_LANES; l++) total_m += occ_m[l];
    up_m = '0;
    dn_m = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      ent = ent_s[e][l];
      ex  = ex_s[e][l];
      set = 1'b0;
      if (ent && !ex) begin
        if (occ_m[l] < MAX_OCC) begin
          occ_m[l]++;
          up_m[l] = 1'b1;
        end else set = 1'b1;
      end else if (ex && !ent) begin
        if (occ_m[l] > 0) begin
          occ_m[l]--;
          dn_m[l] = 1'b1;
        end else set = 1'b1;
      end
      if (err_clr) err_m[l] = 1'b0;
      else if (set) err_m[l] = 1'b1;
    end
    ent_s[e] = '0;
    ex_s[e]  = '0;
  endtask

  task automatic tick();
    logic [NUM_LANES*CNT_W-1:0] eo;
    logic [NUM_LANES-1:0]       ef, ee, er;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC - 16) begin
      $display("[TB] FAIL cycle_budget: observed %0d expected below %0d", cyc, MAXC - 16);
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    model_edge(cyc);
    for (int l = 0; l < NUM_LANES; l++) begin
      eo[l*CNT_W +: CNT_W] = CNT_W'(occ_m[l]);
      ef[l] = (occ_m[l] == MAX_OCC);
      ee[l] = (occ_m[l] == 0);
      er[l] = err_m[l];
    end
    checkOutput("occ", 64'(occ), 64'(eo));
    checkOutput("up_pulse", 64'(up_pulse), 64'(up_m));
    checkOutput("down_pulse", 64'(down_pulse), 64'(dn_m));
    checkOutput("full", 64'(full), 64'(ef));
    checkOutput("empty", 64'(empty), 64'(ee));
    checkOutput("err", 64'(err), 64'(er));
    checkOutput("total", 64'(total), 64'(total_m));
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_occ"}, 64'(occ), 64'd0);
    checkOutput({tag, "_up"}, 64'(up_pulse), 64'd0);
    checkOutput({tag, "_down"}, 64'(down_pulse), 64'd0);
    checkOutput({tag, "_full"}, 64'(full), 64'd0);
    checkOutput({tag, "_empty"}, 64'(empty), 64'hF);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
    checkOutput({tag, "_total"}, 64'(total), 64'd0);
  endtask

  task automatic reset_tick();
    @(posedge clk);
    #1;
    cyc++;
    check_reset_values("rst");
  endtask

  task automatic hold(input int n, input logic clr);
    for (int k = 0; k < n; k++) begin
      applyStimulus(fs_cur, bs_cur, clr);
      tick();
      clr = 1'b0;
    end
  endtask

  task automatic pulse_sensor(input bit back, input int lane, input int hi, input int lo);
    if (back) bs_cur[lane] = 1'b1;
    else      fs_cur[lane] = 1'b1;
    hold(hi, 1'b0);
    if (back) bs_cur[lane] = 1'b0;
    else      fs_cur[lane] = 1'b0;
    hold(lo, 1'b0);
  endtask

  function automatic logic [CNT_W-1:0] lane_occ(input int lane);
    return occ[lane*CNT_W +: CNT_W];
  endfunction

  initial begin
    int seen;
    int npulse;
    bit lvl[NSENS];
    int rem[NSENS];
    logic [NUM_LANES-1:0] rfs, rbs;

    model_reset();
    repeat (3) reset_tick();
    rst = 1'b0;
    model_reset();
    hold(6, 1'b0);

    // single clean entry on lane 0: pulse timing and follow-on state
    $display("[TB] lane 0 entry latency");
    fs_cur[0] = 1'b1;
    seen   = 0;
    npulse = 0;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(fs_cur, bs_cur, 1'b0);
      tick();
      if (up_pulse[0]) begin
        npulse++;
        if (seen == 0) seen = k;
      end
    end
    checkOutput("entry_latency", 64'(seen), 64'(LAT));
    checkOutput("entry_pulse_count", 64'(npulse), 64'd1);
    fs_cur[0] = 1'b0;
    hold(DEB_EFF + 3, 1'b0);
    checkOutput("entry_occ0", 64'(lane_occ(0)), 64'd1);
    checkOutput("entry_empty0", 64'(empty[0]), 64'd0);

    // 3-cycle glitch on lane 1
    $display("[TB] lane 1 glitch");
    pulse_sensor(1'b0, 1, 3, LAT + 4);
    checkOutput("glitch_occ1", 64'(lane_occ(1)), (3 >= DEB_EFF) ? 64'd1 : 64'd0);

    // exit on an empty lane 3
    $display("[TB] lane 3 underflow");
    pulse_sensor(1'b1, 3, DEB_EFF + 1, LAT + 2);
    checkOutput("underflow_occ3", 64'(lane_occ(3)), 64'd0);
    checkOutput("underflow_err3", 64'(err[3]), 64'd1);
    hold(1, 1'b1);
    hold(1, 1'b0);
    checkOutput("underflow_err3_clr", 64'(err[3]), 64'd0);

    // simultaneous entry and exit on lane 0 with occ = 5
    $display("[TB] lane 0 simultaneous entry and exit");
    repeat (4) pulse_sensor(1'b0, 0, DEB_EFF + 1, DEB_EFF + 2);
    hold(LAT, 1'b0);
    checkOutput("simul_pre_occ0", 64'(lane_occ(0)), 64'd5);
    fs_cur[0] = 1'b1;
    bs_cur[0] = 1'b1;
    hold(DEB_EFF + 1, 1'b0);
    fs_cur[0] = 1'b0;
    bs_cur[0] = 1'b0;
    hold(LAT + 3, 1'b0);
    checkOutput("simul_occ0", 64'(lane_occ(0)), 64'd5);
    checkOutput("simul_err0", 64'(err[0]), 64'd0);

    // reset in the middle of a pending entry, sensor held through release
    $display("[TB] lane 0 reset mid-event");
    repeat (2) pulse_sensor(1'b1, 0, DEB_EFF + 1, DEB_EFF + 2);
    hold(LAT, 1'b0);
    checkOutput("midrst_pre_occ0", 64'(lane_occ(0)), 64'd3);
    fs_cur[0] = 1'b1;
    hold(3, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    repeat (2) reset_tick();
    rst = 1'b0;
    model_reset();
    hold(12 + DEB_EFF, 1'b0);
    checkOutput("midrst_held_occ0", 64'(lane_occ(0)), 64'd0);
    fs_cur[0] = 1'b0;
    hold(DEB_EFF + 4, 1'b0);
    pulse_sensor(1'b0, 0, DEB_EFF + 1, LAT + 2);
    checkOutput("midrst_recount_occ0", 64'(lane_occ(0)), 64'd1);

    // fill lane 2 to capacity, then one more entry
    $display("[TB] lane 2 overflow");
    repeat (MAX_OCC + 1) pulse_sensor(1'b0, 2, DEB_EFF + 1, DEB_EFF + 2);
    hold(LAT, 1'b0);
    checkOutput("overflow_occ2", 64'(lane_occ(2)), 64'(MAX_OCC));
    checkOutput("overflow_full2", 64'(full[2]), 64'd1);
    checkOutput("overflow_err2", 64'(err[2]), 64'd1);
    hold(1, 1'b1);
    hold(1, 1'b0);
    checkOutput("overflow_err2_clr", 64'(err[2]), 64'd0);

    // random sensor waveforms on every lane
    $display("[TB] random traffic");
    for (int s = 0; s < NSENS; s++) begin
      lvl[s] = 1'b0;
      rem[s] = $urandom_range(1, 2 * DEB_EFF + 4);
    end
    for (int c = 0; c < 1500; c++) begin
      for (int s = 0; s < NSENS; s++) begin
        if (rem[s] == 0) begin
          lvl[s] = ~lvl[s];
          rem[s] = $urandom_range(1, 2 * DEB_EFF + 4);
        end else begin
          rem[s]--;
        end
      end
      for (int l = 0; l < NUM_LANES; l++) begin
        rfs[l] = lvl[l];
        rbs[l] = lvl[l + NUM_LANES];
      end
      fs_cur = rfs;
      bs_cur = rbs;
      hold(1, ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
    end
    fs_cur = '0;
    bs_cur = '0;
    hold(LAT + DEB_EFF + 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
